// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions: default Q(INTW.RATW) format, width
// helpers and the sequential-datapath FSM encoding.
package fixed_pkg;

  localparam int INTW_DEF = 10;
  localparam int RATW_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand width of a Q(intw.ratw) value.
  function automatic int w_of(input int intw, input int ratw);
    return intw + ratw;
  endfunction

  // Product width after dropping the upper integer bits: Q(intw.2*ratw).
  function automatic int pw_of(input int intw, input int ratw);
    return intw + 2 * ratw;
  endfunction

  // Full, never-overflowing product width of two operands.
  function automatic int fw_of(input int intw, input int ratw);
    return 2 * (intw + ratw);
  endfunction

endpackage

// File: rtl/fixed_sat.sv
// Combinational saturator: narrows an FW-bit value to PW bits, replacing
// anything that does not fit with all-ones and flagging it.
module fixed_sat #(
  parameter int FW = 24,
  parameter int PW = 14
) (
  input  logic [FW-1:0] full,
  output logic [PW-1:0] sat,
  output logic          ovf
);

  // Any set bit above PW means the value cannot be represented.
  always_comb begin
    ovf = |full[FW-1:PW];
    sat = ovf ? {PW{1'b1}} : full[PW-1:0];
  end

endmodule

// File: rtl/fixed_mul_seq.sv
// Sequential radix-2 shift-add unsigned fixed-point multiplier.
// Q(INTW.RATW) x Q(INTW.RATW) -> saturated Q(INTW.2*RATW), one multiplier
// bit per cycle, fixed latency of W cycles from accept to out_valid.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE, so operands are taken once per
// operation; out_valid stays high and out_data/out_ovf stay stable until
// the consumer raises out_ready. ready never depends on valid.
module fixed_mul_seq
  import fixed_pkg::*;
#(
  parameter int INTW = INTW_DEF,
  parameter int RATW = RATW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [w_of(INTW,RATW)-1:0]  in_a,
  input  logic [w_of(INTW,RATW)-1:0]  in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [pw_of(INTW,RATW)-1:0] out_data,
  output logic                   out_ovf
);

  localparam int W  = w_of(INTW, RATW);
  localparam int PW = pw_of(INTW, RATW);
  localparam int FW = fw_of(INTW, RATW);
  localparam int CW = $clog2(W + 1);

  state_t        state;
  state_t        state_nxt;
  logic [FW-1:0] acc;
  logic [FW-1:0] mcand;
  logic [FW-1:0] acc_nxt;
  logic [W-1:0]  mplr;
  logic [CW-1:0] cnt;
  logic          last_iter;
  logic [PW-1:0] sat_data;
  logic          sat_ovf;

  // Accumulator value after this cycle's partial product; the final
  // iteration's value feeds the saturator directly so DONE sees it at once.
  assign acc_nxt   = mplr[0] ? (acc + mcand) : acc;
  assign last_iter = (cnt == CW'(W - 1));

  fixed_sat #(
    .FW(FW),
    .PW(PW)
  ) u_sat (
    .full(acc_nxt),
    .sat (sat_data),
    .ovf (sat_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accept, iterate W times, hold until the result is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational output decode of the state.
  always_comb begin
    in_ready = (state == IDLE);
  end

  // Shift-add datapath: load on accept, one multiplier bit per BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else if (state == IDLE && in_valid) begin
      acc   <= '0;
      mcand <= {{(FW - W){1'b0}}, in_a};
      mplr  <= in_b;
      cnt   <= '0;
    end else if (state == BUSY) begin
      acc   <= acc_nxt;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

  // Registered result: captured on the final iteration, held through DONE
  // and kept after the handshake until the next result or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= (state_nxt == DONE);
      if (state == BUSY && last_iter) begin
        out_data <= sat_data;
        out_ovf  <= sat_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fixed_mul_seq.sv
// Bench for fixed_mul_seq: directed steps plus randomized operands checked
// against an arithmetic product model and a software rounding model.
module tb_fixed_mul_seq;
  import fixed_pkg::*;

  localparam int INTW = INTW_DEF;
  localparam int RATW = RATW_DEF;
  localparam int W    = INTW + RATW;
  localparam int PW   = INTW + 2 * RATW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic          out_ovf;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected result per accepted operation.
  logic [PW-1:0] exp_q[$];
  logic          exp_ovf_q[$];

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  fixed_mul_seq #(.INTW(INTW), .RATW(RATW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  // Reference model: exact integer product, saturated to PW bits.
  task automatic model_push(input int unsigned a, input int unsigned b);
    longint unsigned p;
    logic [63:0]     pv;
    logic            o;
    p  = longint'(a) * longint'(b);
    pv = p;
    o  = (p >= (64'd1 << PW));
    exp_ovf_q.push_back(o);
    exp_q.push_back(o ? {PW{1'b1}} : pv[PW-1:0]);
  endtask

  // Round stage: Q(INTW.2*RATW) -> Q(INTW.RATW), round half up.
  function automatic int unsigned round_stage(input logic [PW-1:0] d);
    return (int'(d) + (1 << (RATW - 1))) >> RATW;
  endfunction

  // Software rounding from real-valued operands.
  function automatic int unsigned sw_round(input int unsigned a, input int unsigned b);
    real v;
    v = (real'(a) / 4.0) * (real'(b) / 4.0);
    return int'($floor(v * 4.0 + 0.5));
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands, wait for in_ready, and leave right after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("accept_wait", 32'(n < 100), 32'd1);
    model_push(a, b);
    tick();
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge; out_valid must rise W edges later.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(W));
  endtask

  task automatic check_result(input string tag);
    logic [PW-1:0] e;
    logic          eo;
    e  = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    chk({tag, "_data"}, 32'(out_data), 32'(e));
    chk({tag, "_ovf"},  32'(out_ovf),  32'(eo));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rel_ready"}, 32'(in_ready),  32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(a, b);
    wait_valid(tag);
    check_result(tag);
    release_result(tag);
  endtask

  // Directed and random stimulus, then the final report.
  initial begin
    int            seen;
    logic [PW-1:0] held;
    int unsigned   ra;
    int unsigned   rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_ovf",   32'(out_ovf),   32'd0);

    // Basic, saturating and edge operands.
    run_op("basic",   12'h00A, 12'h00C);
    run_op("sat",     12'hFFF, 12'hFFF);
    run_op("zero_a",  12'h000, 12'hABC);
    run_op("zero_b",  12'h5A5, 12'h000);
    run_op("one_x",   12'h004, 12'h3FF);

    // out_ready already high before DONE: result still appears after W.
    out_ready = 1'b1;
    start_op(12'h010, 12'h021);
    wait_valid("early_rdy");
    check_result("early_rdy");
    tick();
    out_ready = 1'b0;
    chk("early_rdy_consumed", 32'(out_valid), 32'd0);

    // Backpressure with a competing request held on the input.
    start_op(12'h123, 12'h045);
    wait_valid("bp");
    held     = exp_q[0];
    in_valid = 1'b1;
    in_a     = 12'h777;
    in_b     = 12'h111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_ready", 32'(in_ready),  32'd0);
      chk("bp_data",  32'(out_data),  32'(held));
    end
    check_result("bp");
    release_result("bp");
    model_push(12'h777, 12'h111);
    tick();
    in_valid = 1'b0;
    wait_valid("bp_next");
    check_result("bp_next");
    release_result("bp_next");

    // Reset on the sixth BUSY edge aborts the operation.
    start_op(12'h0FF, 12'h0FF);
    void'(exp_q.pop_back());
    void'(exp_ovf_q.pop_back());
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready",  32'(in_ready),  32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data",  32'(out_data),  32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    run_op("after_abort", 12'h006, 12'h006);

    // Random products that fit in PW bits, checked through rounding too.
    for (int i = 0; i < 100; i++) begin
      ra = $urandom_range(4095, 1);
      rb = $urandom_range(((1 << PW) - 1) / ra, 0);
      start_op(W'(ra), W'(rb));
      wait_valid("rnd");
      check_result("rnd");
      chk("rnd_round", round_stage(out_data), sw_round(ra, rb));
      release_result("rnd");
    end

    // Random full-range operands, mostly saturating.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom_range(4095, 0);
      rb = $urandom_range(4095, 0);
      run_op("rnd_full", W'(ra), W'(rb));
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_mul_seq.md
Name: fixed_mul_seq

Overview:
- Sequential radix-2 shift-add unsigned fixed-point multiplier.
- Sits directly upstream of the round stage. It multiplies two Q(INTW.RATW) operands and produces a Q(INTW.2*RATW) product, which the round stage consumes.
- One multiplier bit per cycle with fixed latency. Valid/ready handshake on both input and output.
- Saturates the product to the round stage's input width and flags overflow.

Parameters:
- INTW, 10, integer bits per operand and of the output.
- RATW, 2, fraction bits per operand; the output carries 2*RATW fraction bits.
- Derived, not overridable: W = INTW+RATW (operand width); PW = INTW+2*RATW (output width); FW = 2*W (full product width); CW = $clog2(W+1) (counter width).

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, reset; synchronous, active-high.
- in_valid, in, 1, operands present.
- in_ready, out, 1, block can accept operands.
- in_a, in, W, multiplicand, unsigned Q(INTW.RATW).
- in_b, in, W, multiplier, unsigned Q(INTW.RATW).
- out_valid, out, 1, result present.
- out_ready, in, 1, consumer accepts the result.
- out_data, out, PW, product in Q(INTW.2*RATW), saturated.
- out_ovf, out, 1, full product exceeded PW bits.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; acc, mcand, mplr and cnt cleared.
  - out_valid=0, out_data=0, out_ovf=0; in_ready=1 after the edge.
  - Reset wins over every other event and aborts any operation in flight, with no output produced.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE), decoded combinationally. out_valid = (state==DONE), registered.
- IDLE:
  - If in_valid && in_ready at an edge: mcand <= zero-extended in_a (FW bits); mplr <= in_b; acc <= 0; cnt <= 0; state <= BUSY.
  - in_a and in_b are not sampled at any other time.
- BUSY, each edge:
  - If mplr[0], acc <= acc + mcand (FW bits, never overflows).
  - mcand <= mcand<<1; mplr <= mplr>>1; cnt <= cnt+1.
  - On the edge where cnt==W-1, the final iteration is applied and state <= DONE.
- DONE entry, same edge as the final iteration, using the final acc value:
  - out_ovf <= |acc_final[FW-1:PW].
  - out_data <= out_ovf ? all-ones (PW bits) : acc_final[PW-1:0].
  - The upper INTW bits are dropped; the binary point lands at bit 2*RATW, exactly as the round stage requires.
- DONE:
  - out_data and out_ovf hold stable while out_valid && !out_ready.
  - On out_valid && out_ready at an edge: state <= IDLE, out_valid <= 0. out_data and out_ovf keep their last value.
- Latency: accept at edge T; out_valid is high from edge T+W. With W=12, the result is visible 12 cycles after the accept edge.
- Throughput: at best one result per W+2 cycles. There is no overlap: in_ready stays low during BUSY and DONE, and in_valid is ignored there.
- Boundary conditions:
  - in_b=0: runs the full W cycles and yields 0 (no early termination).
  - Operand all-ones: the accumulator reaches its maximum without wrap.
  - in_valid may stay high across results; a new accept is possible only in IDLE.
  - out_ready high before DONE has no effect.

Decomposition:
- Shared package fixed_pkg:
  - Default INTW and RATW.
  - Width helper functions for W, PW and FW.
  - FSM state encodings: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - This package is also used by round and its bench.
- One sub-module, fixed_sat: combinational, FW bits in, PW bits out plus an ovf bit. It performs the upper-bit OR-reduce and all-ones substitution, and is reusable by other fixed-point producers.

Test Plan (INTW=10, RATW=2):
- Basic product: in_a=12'h00A (2.5), in_b=12'h00C (3.0) -> out_data=14'h0078 (7.5), out_ovf=0. out_valid rises exactly 12 cycles after the accept edge.
- Saturation: in_a=in_b=12'hFFF -> full product 24'hFFE001; out_data=14'h3FFF, out_ovf=1.
- Zero and edge operands:
  - in_a=0, in_b=12'hABC -> 14'h0000 after the full 12-cycle latency.
  - in_a=12'h004 (1.0), in_b=12'h3FF -> 14'h0FFC, out_ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, and drive a new in_valid. out_data stays stable, in_ready=0 and the new operands are not accepted. Release out_ready -> in_ready=1 the next cycle, then the next operation runs.
- Reset mid-operation: assert rst on cycle 6 of BUSY -> next cycle state=IDLE, in_ready=1, out_valid never rises for the aborted operation. A following operation with 12'h006 x 12'h006 gives 14'h0024 (2.25).
- Chained into round: 100 random operand pairs with products below 2**PW. Compare out_data against the software product, then compare round(out_data) against the software-rounded value, with all 100 passing.
